// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat
//   Push-button front end. Each key channel synchronises its raw level,
//   debounces it and produces clean single-cycle press/release pulses, with
//   optional hold-to-autorepeat on the press pulse.
// Ports
//   clk            system clock, all logic on posedge
//   reset          asynchronous active-low reset
//   keys_in        raw asynchronous button levels, one bit per key
//   repeat_en      1 = autorepeat enabled on every channel
//   press_pulse    1-cycle pulse per accepted press and per repeat
//   release_pulse  1-cycle pulse per accepted release
//   held           debounced pressed level
module key_debounce_repeat #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] keys_in,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] held
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RPT_DLY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PER  = CW'(REPEAT_PERIOD);
    localparam logic          RELEASED = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] p;

    // Sync flops reset to the released raw level so reset release never
    // looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= {N_KEYS{RELEASED}};
            sync2 <= {N_KEYS{RELEASED}};
        end else begin
            sync1 <= keys_in;
            sync2 <= sync1;
        end
    end

    // Normalised level: 1 = pressed.
    always_comb begin
        p = (KEY_ACTIVE_LOW != 0) ? ~sync2 : sync2;
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_ch
        state_t        state, state_n;
        logic [CW-1:0] cnt, cnt_n;
        logic [CW-1:0] rpt, rpt_n;
        logic [CW-1:0] rpt_inc;
        logic          first, first_n;
        logic          press_q, press_n;
        logic          rel_q, rel_n;
        logic          held_q, held_n;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state   <= IDLE;
                cnt     <= '0;
                rpt     <= '0;
                first   <= 1'b1;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                held_q  <= 1'b0;
            end else begin
                state   <= state_n;
                cnt     <= cnt_n;
                rpt     <= rpt_n;
                first   <= first_n;
                press_q <= press_n;
                rel_q   <= rel_n;
                held_q  <= held_n;
            end
        end

        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            rpt_n   = rpt;
            first_n = first;
            press_n = 1'b0;
            rel_n   = 1'b0;
            held_n  = held_q;
            rpt_inc = rpt + 1'b1;
            case (state)
                IDLE: begin
                    if (p[k]) begin
                        state_n = PRESS_CHK;
                        cnt_n   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!p[k]) begin
                        state_n = IDLE;
                    end else if (cnt == DB_LAST) begin
                        state_n = HELD;
                        press_n = 1'b1;
                        held_n  = 1'b1;
                        rpt_n   = '0;
                        first_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!p[k]) begin
                        state_n = REL_CHK;
                        cnt_n   = '0;
                    end else if (repeat_en) begin
                        // First repeat waits the long delay, later ones the period.
                        if (rpt_inc == (first ? RPT_DLY : RPT_PER)) begin
                            press_n = 1'b1;
                            rpt_n   = '0;
                            first_n = 1'b0;
                        end else begin
                            rpt_n = rpt_inc;
                        end
                    end else begin
                        rpt_n   = '0;
                        first_n = 1'b1;
                    end
                end
                REL_CHK: begin
                    // rpt is left untouched here so a bounce resumes the repeat phase.
                    if (p[k]) begin
                        state_n = HELD;
                    end else if (cnt == DB_LAST) begin
                        state_n = IDLE;
                        rel_n   = 1'b1;
                        held_n  = 1'b0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        assign press_pulse[k]   = press_q;
        assign release_pulse[k] = rel_q;
        assign held[k]          = held_q;
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat
//   Scoreboard bench for key_debounce_repeat (N_KEYS=2, DEBOUNCE=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3). A reference model pushes the expected
//   outputs after every clock edge; a monitor pops and compares on the
//   falling edge. Directed cases first, then randomised key activity.
module tb_key_debounce_repeat;

    localparam int NK = 2;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic          clk;
    logic          reset;
    logic [NK-1:0] keys_in;
    logic          repeat_en;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;
    logic [NK-1:0] held;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    typedef struct packed {
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic [NK-1:0] hd;
    } exp_t;

    exp_t q[$];

    key_debounce_repeat #(
        .N_KEYS         (NK),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keys_in      (keys_in),
        .repeat_en    (repeat_en),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw level delayed two edges, accepted level flips after
    // D+1 consecutive edges of disagreement; hold time counted only on edges
    // where the key is steadily held and agrees with the accepted level.
    bit m_s1[NK];
    bit m_s2[NK];
    bit m_acc[NK];
    int m_run[NK];
    int m_rpt[NK];
    bit m_first[NK];

    always @(posedge clk or negedge reset) begin
        exp_t e;
        bit   pk;
        e = '0;
        if (!reset) begin
            for (int k = 0; k < NK; k++) begin
                m_s1[k] = 1'b1;
                m_s2[k] = 1'b1;
                m_acc[k] = 1'b0;
                m_run[k] = 0;
                m_rpt[k] = 0;
                m_first[k] = 1'b1;
            end
            q.delete();
            if (started) q.push_back(e);
        end else begin
            for (int k = 0; k < NK; k++) begin
                pk = ~m_s2[k];
                m_s2[k] = m_s1[k];
                m_s1[k] = keys_in[k];
                if (pk != m_acc[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D + 1) begin
                        m_acc[k] = pk;
                        m_run[k] = 0;
                        if (pk) begin
                            e.pr[k] = 1'b1;
                            m_rpt[k] = 0;
                            m_first[k] = 1'b1;
                        end else begin
                            e.rl[k] = 1'b1;
                        end
                    end
                end else begin
                    if (m_acc[k] && m_run[k] == 0) begin
                        if (repeat_en) begin
                            m_rpt[k]++;
                            if (m_rpt[k] == (m_first[k] ? RD : RP)) begin
                                e.pr[k] = 1'b1;
                                m_rpt[k] = 0;
                                m_first[k] = 1'b0;
                            end
                        end else begin
                            m_rpt[k] = 0;
                            m_first[k] = 1'b1;
                        end
                    end
                    m_run[k] = 0;
                end
                e.hd[k] = m_acc[k];
            end
            if (started) q.push_back(e);
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow t=%0t: no expected entry", $time);
            end else begin
                e = q.pop_front();
                if (press_pulse !== e.pr || release_pulse !== e.rl || held !== e.hd) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got press=%b rel=%b held=%b, want press=%b rel=%b held=%b",
                             $time, press_pulse, release_pulse, held, e.pr, e.rl, e.hd);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic anchor(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t: got %b want %b", name, $time, got, want);
        end
    endtask

    task automatic release_and_idle();
        keys_in = 2'b11;
        step(14);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        keys_in   = 2'b11;
        repeat_en = 1'b0;
        @(negedge clk);
        #1 started = 1;
        step(3);
        reset = 1'b1;
        step(3);

        // Case 1 + 3: single press, then release
        keys_in = 2'b10;
        step(6);
        anchor("c1_no_early_press", press_pulse, 2'b00);
        step(1);
        anchor("c1_press_edge7", press_pulse, 2'b01);
        anchor("c1_held_edge7", held, 2'b01);
        step(22);
        keys_in = 2'b11;
        step(6);
        anchor("c3_no_early_release", release_pulse, 2'b00);
        step(1);
        anchor("c3_release_edge36", release_pulse, 2'b01);
        anchor("c3_held_cleared", held, 2'b00);
        step(12);

        // Case 2: glitches in PRESS_CHK and a bounce while held
        keys_in = 2'b10; step(3);
        keys_in = 2'b11; step(3);
        for (int i = 0; i < 3; i++) begin
            keys_in = 2'b10; step(3);
            keys_in = 2'b11; step(1);
        end
        keys_in = 2'b10; step(12);
        keys_in = 2'b11; step(1);
        keys_in = 2'b10; step(10);
        anchor("c2_held_after_bounce", held, 2'b01);
        release_and_idle();

        // Case 4: autorepeat, then repeat_en dropped
        repeat_en = 1'b1;
        keys_in = 2'b10;
        step(7);
        anchor("c4_press_edge7", press_pulse, 2'b01);
        step(10);
        anchor("c4_repeat_edge17", press_pulse, 2'b01);
        step(3);
        anchor("c4_repeat_edge20", press_pulse, 2'b01);
        repeat_en = 1'b0;
        step(3);
        anchor("c4_no_repeat_edge23", press_pulse, 2'b00);
        step(17);
        release_and_idle();

        // Case 5: async reset while held, key kept low
        keys_in = 2'b10;
        step(12);
        reset = 1'b0;
        #1;
        anchor("c5_async_held_clear", held, 2'b00);
        step(3);
        reset = 1'b1;
        step(6);
        anchor("c5_no_early_press", press_pulse, 2'b00);
        step(1);
        anchor("c5_press_edge22", press_pulse, 2'b01);
        release_and_idle();

        // Case 6: simultaneous presses
        keys_in = 2'b00;
        step(7);
        anchor("c6_both_press", press_pulse, 2'b11);
        step(1);
        anchor("c6_single_cycle", press_pulse, 2'b00);
        release_and_idle();

        // Random key activity
        for (int i = 0; i < 60; i++) begin
            keys_in   = 2'($urandom_range(0, 3));
            repeat_en = 1'($urandom_range(0, 1));
            step($urandom_range(1, 16));
        end
        release_and_idle();

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
